// File: rtl/kernel_loader.sv
// rtl/kernel_loader.sv - stages one kernel from a valid/ready stream, then flushes and bursts it gap-free to the weight buffer (optional checksum: KERNEL_LOADER_CHECKSUM_EN)
module kernel_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [7:0]            kernel_size,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  wb_busy,
  output logic                  wb_flush,
  output logic                  wb_valid,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  done,
`ifdef KERNEL_LOADER_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0] ksum,
`endif
  output logic                  cfg_err
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0]  L_DEPTH = 8'(DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_ARM     = 3'd2;
  localparam logic [2:0] S_FLUSH   = 3'd3;
  localparam logic [2:0] S_STREAM  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]            r_state;
  logic [7:0]            r_kn;
  logic [7:0]            r_wr_cnt;
  logic [7:0]            r_rd_ptr;
  logic                  r_cfg_err;
  logic [DATA_WIDTH-1:0] r_stage [DEPTH];

  logic                  w_size_bad;
  logic                  w_ready;
  logic                  w_accept;
  logic [AW-1:0]         w_wr_addr;

  // An oversized kernel request blocks acceptance in IDLE instead of overrunning the stage.
  assign w_size_bad = (kernel_size >= L_DEPTH);
  assign w_ready    = ((r_state == S_IDLE) && !w_size_bad) || (r_state == S_COLLECT);
  assign w_accept   = s_valid && w_ready;
  assign w_wr_addr  = (r_state == S_IDLE) ? '0 : r_wr_cnt[AW-1:0];

  assign s_ready  = rstn && w_ready;
  assign wb_flush = (r_state == S_FLUSH);
  assign wb_valid = (r_state == S_STREAM);
  assign wb_data  = (r_state == S_STREAM) ? r_stage[r_rd_ptr[AW-1:0]] : '0;
  assign done     = (r_state == S_DONE);
  assign cfg_err  = r_cfg_err;

  // Staging RAM: not reset, every read location is written earlier in the same kernel.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_stage[w_wr_addr] <= s_data;
    end
  end

  // Main sequencer: collect, wait for buffer idle, flush, stream, signal done.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_kn     <= '0;
      r_wr_cnt <= '0;
      r_rd_ptr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_kn     <= kernel_size;
            r_wr_cnt <= 8'd1;
            r_state  <= (kernel_size == 8'd0) ? S_ARM : S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (w_accept) begin
            r_wr_cnt <= r_wr_cnt + 8'd1;
            if (r_wr_cnt == r_kn) begin
              r_state <= S_ARM;
            end
          end
        end
        S_ARM: begin
          if (!wb_busy) begin
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          r_rd_ptr <= '0;
          r_state  <= S_STREAM;
        end
        S_STREAM: begin
          r_rd_ptr <= r_rd_ptr + 8'd1;
          if (r_rd_ptr == r_kn) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_wr_cnt <= '0;
          r_rd_ptr <= '0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Configuration error is sticky until reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cfg_err <= 1'b0;
    end else if ((r_state == S_IDLE) && w_size_bad) begin
      r_cfg_err <= 1'b1;
    end
  end

`ifdef KERNEL_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_ksum;

  assign ksum = r_ksum;

  // Running XOR of streamed words, published on DONE and held until the next kernel completes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc  <= '0;
      r_ksum <= '0;
    end else begin
      if (r_state == S_FLUSH) begin
        r_acc <= '0;
      end else if (r_state == S_STREAM) begin
        r_acc <= r_acc ^ wb_data;
      end
      if (r_state == S_DONE) begin
        r_ksum <= r_acc;
      end
    end
  end
`endif

endmodule

// File: tb/tb_kernel_loader.sv
// tb/tb_kernel_loader.sv - per-cycle vector table plus reset sequences for kernel_loader (KERNEL_LOADER_CHECKSUM_EN adds ksum checks)
module tb_kernel_loader;

  typedef struct {
    logic [7:0]  ks;
    logic        sv;
    logic [15:0] sd;
    logic        busy;
    logic        e_ready;
    logic        e_flush;
    logic        e_valid;
    logic [15:0] e_data;
    logic        e_done;
    logic        e_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  kernel_size;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        wb_busy;
  logic        wb_flush;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic        done;
  logic        cfg_err;
`ifdef KERNEL_LOADER_CHECKSUM_EN
  logic [15:0] ksum;
`endif

  int n_vec = 0;
  int n_err = 0;
  vec_t        vecs[$];
  logic [15:0] kw[$];

  kernel_loader #(.DATA_WIDTH(16), .DEPTH(16)) dut (
    .clk(clk),
    .rstn(rstn),
    .kernel_size(kernel_size),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .wb_busy(wb_busy),
    .wb_flush(wb_flush),
    .wb_valid(wb_valid),
    .wb_data(wb_data),
    .done(done),
`ifdef KERNEL_LOADER_CHECKSUM_EN
    .ksum(ksum),
`endif
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  function automatic void push(input logic [7:0] ks, input logic sv, input logic [15:0] sd,
                               input logic busy, input logic e_ready, input logic e_flush,
                               input logic e_valid, input logic [15:0] e_data,
                               input logic e_done, input logic e_err);
    vec_t v;
    v.ks = ks; v.sv = sv; v.sd = sd; v.busy = busy;
    v.e_ready = e_ready; v.e_flush = e_flush; v.e_valid = e_valid;
    v.e_data = e_data; v.e_done = e_done; v.e_err = e_err;
    vecs.push_back(v);
  endfunction

  // Accept kw back-to-back starting in IDLE.
  function automatic void add_accepts(input logic [7:0] ks, input logic busy, input logic err);
    foreach (kw[i]) push(ks, 1'b1, kw[i], busy, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, err);
  endfunction

  // Expected cycles after the last accept: ARM, FLUSH, stream of kw, DONE, back in IDLE.
  function automatic void add_tail(input logic [7:0] ks, input logic err);
    push(ks, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, err);
    push(ks, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, err);
    foreach (kw[i]) push(ks, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, kw[i], 1'b0, err);
    push(ks, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, err);
    push(ks, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, err);
  endfunction

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got rdy/fl/val/data/done/err=%b/%b/%b/%h/%b/%b want %b/%b/%b/%h/%b/%b",
               name, act[20], act[19], act[18], act[17:2], act[1], act[0],
               exp[20], exp[19], exp[18], exp[17:2], exp[1], exp[0]);
    end
  endtask

  task automatic apply_all(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      kernel_size = vecs[i].ks;
      s_valid     = vecs[i].sv;
      s_data      = vecs[i].sd;
      wb_busy     = vecs[i].busy;
      #1;
      check($sformatf("%s_v%0d", tag, i),
            {s_ready, wb_flush, wb_valid, wb_data, done, cfg_err},
            {vecs[i].e_ready, vecs[i].e_flush, vecs[i].e_valid, vecs[i].e_data,
             vecs[i].e_done, vecs[i].e_err});
    end
    vecs.delete();
  endtask

  initial begin
    rstn = 1'b0; kernel_size = 8'd8; s_valid = 1'b0; s_data = 16'h0; wb_busy = 1'b0;
    #12;
    check("reset_outputs", {s_ready, wb_flush, wb_valid, wb_data, done, cfg_err}, 21'h0);
`ifdef KERNEL_LOADER_CHECKSUM_EN
    n_vec++;
    if (ksum !== 16'h0) begin n_err++; $display("FAIL ksum_reset: got %h want 0000", ksum); end
`endif
    @(negedge clk);
    rstn = 1'b1;

    // kernel_size=8, words 1..9 back-to-back
    kw = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
    add_accepts(8'd8, 1'b0, 1'b0);
    add_tail(8'd8, 1'b0);

    // single-word kernel
    kw = '{16'hABCD};
    add_accepts(8'd0, 1'b0, 1'b0);
    add_tail(8'd0, 1'b0);

    // s_valid toggling 1,0,0,1,1,0,1; kernel_size changed after latching
    push(8'd3, 1'b1, 16'h0011, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    push(8'd9, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    push(8'd9, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    push(8'd9, 1'b1, 16'h0022, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    push(8'd9, 1'b1, 16'h0033, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    push(8'd9, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    push(8'd9, 1'b1, 16'h0044, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    kw = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    add_tail(8'd9, 1'b0);

    // collected while wb_busy=1; ARM held 5 extra cycles
    kw = '{16'h00A1, 16'h00A2};
    add_accepts(8'd1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) push(8'd1, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    add_tail(8'd1, 1'b0);

    // kernel_size=16 rejected, cfg_err sticky, normal load still works
    push(8'd16, 1'b1, 16'h0077, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    push(8'd16, 1'b1, 16'h0077, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    push(8'd2,  1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    kw = '{16'h0101, 16'h0202, 16'h0303};
    add_accepts(8'd2, 1'b0, 1'b1);
    add_tail(8'd2, 1'b1);

    apply_all("tbl");

    // reset after 2 of 4 words accepted
    @(negedge clk);
    kernel_size = 8'd3; s_valid = 1'b1; s_data = 16'h0005;
    @(negedge clk);
    s_data = 16'h0006;
    @(negedge clk);
    s_valid = 1'b0; s_data = 16'h0;
    rstn = 1'b0;
    #1;
    check("midreset_outputs", {s_ready, wb_flush, wb_valid, wb_data, done, cfg_err}, 21'h0);
`ifdef KERNEL_LOADER_CHECKSUM_EN
    n_vec++;
    if (ksum !== 16'h0) begin n_err++; $display("FAIL ksum_midreset: got %h want 0000", ksum); end
`endif
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("postreset_idle%0d", i),
            {s_ready, wb_flush, wb_valid, wb_data, done, cfg_err},
            {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0});
    end

    kw = '{16'h0005, 16'h0006, 16'h0007, 16'h0008};
    add_accepts(8'd3, 1'b0, 1'b0);
    add_tail(8'd3, 1'b0);
    apply_all("reload");
`ifdef KERNEL_LOADER_CHECKSUM_EN
    n_vec++;
    if (ksum !== 16'h000C) begin n_err++; $display("FAIL ksum_reload: got %h want 000c", ksum); end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/kernel_loader.md
# kernel_loader

Upstream feeder for the convolution accelerator's per-PE weight buffer. It accepts kernel weights one word at a time over a valid/ready stream from the DMA/host side and stages a complete kernel locally. Once the buffer reports idle, it issues a one-cycle flush pulse and then replays the kernel as a gap-free burst of one word per cycle. This keeps bursty or stalled host traffic from reaching the weight buffer, which has no back-pressure.

## Interface
Parameters:
- DATA_WIDTH, 16, weight word width
- DEPTH, 16, staging capacity in words (max kernel words)

Ports:
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  reset, asynchronous, active-low
- kernel_size  in  8  kernel words minus one (N = kernel_size+1); latched at first accepted word
- s_valid  in  1  upstream word valid
- s_ready  out  1  loader can accept a word
- s_data  in  DATA_WIDTH  upstream weight word
- wb_busy  in  1  weight buffer is still writing a previous kernel
- wb_flush  out  1  one-cycle pulse that starts a buffer write
- wb_valid  out  1  wb_data carries a kernel word this cycle
- wb_data  out  DATA_WIDTH  kernel word to buffer; 0 when wb_valid=0
- done  out  1  one-cycle pulse after the last word is driven
- cfg_err  out  1  sticky: kernel_size >= DEPTH was presented
- ksum  out  DATA_WIDTH  XOR checksum of last delivered kernel (only with macro, see Configuration)

## Operation
- FSM states: IDLE, COLLECT, ARM, FLUSH, STREAM, DONE.
- Handshake: a word transfers on the rising edge where s_valid && s_ready. s_valid may drop at any time and stalls are unbounded. s_data must be held while s_valid=1 && s_ready=0.
- s_ready = 1 in IDLE and COLLECT only.
- Exception: in IDLE, when kernel_size >= DEPTH, s_ready = 0, no word is accepted and cfg_err sets. cfg_err is cleared only by rstn.
- IDLE: an accepted word is written to stage[0], kernel_size is latched to kn, wr_cnt = 1, and the FSM goes to COLLECT. If kn == 0, it goes directly to ARM.
- COLLECT: each accepted word is written to stage[wr_cnt] and wr_cnt increments. The accept with wr_cnt == kn goes to ARM.
- ARM: wait while wb_busy=1. When wb_busy=0, go to FLUSH.
- FLUSH: wb_flush=1 for exactly this cycle, rd_ptr = 0, then go to STREAM.
- STREAM: wb_valid=1 and wb_data = stage[rd_ptr]; rd_ptr increments each cycle. The cycle with rd_ptr == kn goes to DONE.
- DONE: done=1 for one cycle, then return to IDLE.
- wb_busy is ignored outside ARM.
- Changes to kernel_size after latching have no effect on the kernel in flight.
- Counters are 8 bits and never wrap, because kn < DEPTH <= 255 is enforced.
- Staging RAM is not reset, but its contents are never observable before being written.

## Timing
- Reset values: s_ready=0 while rstn=0, 1 after release (IDLE). wb_flush=0, wb_valid=0, wb_data=0, done=0, cfg_err=0, ksum=0. FSM=IDLE, all counters 0.
- Outputs are decoded from registered state and pointers; no combinational path from s_valid or wb_busy to any output. s_ready depends on the registered state and on kernel_size.
- Let cycle t be the edge accepting the last word. Then:
  - ARM during cycle t+1.
  - With wb_busy=0: wb_flush=1 in t+2.
  - Words 0..kn are driven in cycles t+3 .. t+3+kn.
  - done=1 in t+4+kn.
  - s_ready returns to 1 in t+5+kn.
- Each cycle wb_busy stays high in ARM delays the whole sequence by one cycle.
- Reset asserted mid-operation: all outputs drop to reset values asynchronously. A partial kernel is discarded and no flush follows.

## Configuration
- Macro: KERNEL_LOADER_CHECKSUM_EN.
- Defined:
  - Port ksum exists.
  - An internal accumulator clears in FLUSH and XORs each word driven in STREAM.
  - ksum updates from the accumulator on the DONE cycle and holds until the next DONE.
- Undefined: port ksum and the accumulator are absent. All other behaviour is identical.

## Test plan
- Reset, then kernel_size=8, nine back-to-back words 1..9, wb_busy=0 -> wb_flush one cycle at t+2; wb_data 1..9 in t+3..t+11 with wb_valid=1; done at t+12.
- kernel_size=0, single word 0xABCD -> flush at t+2, one word 0xABCD at t+3, done at t+4.
- kernel_size=3, s_valid toggling 1,0,0,1,1,0,1 (words 0x11..0x44 on the high cycles) -> exactly four accepts; burst is 0x11,0x22,0x33,0x44 with no gaps.
- Kernel collected while wb_busy=1 for 5 cycles -> ARM held 5 extra cycles, s_ready=0 throughout; flush in the first cycle after wb_busy falls, plus one.
- kernel_size=16 with DEPTH=16 -> s_ready stays 0, cfg_err=1 and stays set after kernel_size=2 is applied; a normal load then still works.
- rstn pulsed after 2 of 4 words accepted -> no wb_flush ever; next full load of 0x5,0x6,0x7,0x8 streams correctly. With the macro defined, ksum=0x5^0x6^0x7^0x8=0x0C after done.
